// File: rtl/chip8_pkg.sv
// Shared types and helpers for the CHIP-8 timing blocks.
//   TIMER_W        width of the delay/sound timer registers
//   chip8_timer_t  one CHIP-8 countdown timer value
//   timer_next()   next-value rule for a countdown timer
package chip8_pkg;

  localparam int unsigned TIMER_W = 8;

  typedef logic [TIMER_W-1:0] chip8_timer_t;

  // A load beats a coincident tick; the decrement stops at zero instead of wrapping.
  function automatic chip8_timer_t timer_next(
    input logic         we,
    input chip8_timer_t data,
    input logic         tick,
    input chip8_timer_t cur
  );
    chip8_timer_t nxt;
    nxt = cur;
    if (we) begin
      nxt = data;
    end else if (tick && (cur != '0)) begin
      nxt = cur - TIMER_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/chip8_pulse_div.sv
// Clock divider with a registered one-cycle terminal pulse.
//   clk_in     system clock
//   rst_n_in   asynchronous active-low reset; clears count and pulse
//   en_in      count enable; the count holds while low
//   force_in   requests a pulse next cycle without touching the count
//   pulse_out  high for one cycle after every DIV enabled cycles
module chip8_pulse_div
  import chip8_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en_in,
  input  logic force_in,
  output logic pulse_out
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("chip8_pulse_div: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             term_c;
  logic             pulse_d;

  // Next count and pulse; the count only moves while enabled.
  always_comb begin
    cnt_d   = cnt_q;
    term_c  = en_in && (cnt_q == CNT_LAST);
    if (en_in) begin
      cnt_d = term_c ? '0 : cnt_q + CNT_W'(1);
    end
    pulse_d = term_c || force_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q     <= '0;
      pulse_out <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pulse_out <= pulse_d;
    end
  end

endmodule

// File: rtl/chip8_tick_timer.sv
// Timing source for chip8_processor: instruction strobe, 60 Hz-style timer
// tick, and the CHIP-8 delay (DT) and sound (ST) timer registers.
// Optional feature macro: CHIP8_STEP_EN (single-step strobes while halted).
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   active_in       run enable; both dividers hold while low
//   step_in         single-step request (used only with CHIP8_STEP_EN)
//   dt_we_in/dt_data_in  delay timer load
//   st_we_in/st_data_in  sound timer load
//   chip8_clk_out   one-cycle instruction strobe
//   timer_tick_out  one-cycle tick; DT/ST step down at the end of this cycle
//   dt_out/st_out   current timer values
//   sound_on_out    high while ST is non-zero
module chip8_tick_timer
  import chip8_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned INSTR_HZ = 700,
  parameter int unsigned TIMER_HZ = 60
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               active_in,
  input  logic               step_in,
  input  logic               dt_we_in,
  input  logic [TIMER_W-1:0] dt_data_in,
  input  logic               st_we_in,
  input  logic [TIMER_W-1:0] st_data_in,
  output logic               chip8_clk_out,
  output logic               timer_tick_out,
  output logic [TIMER_W-1:0] dt_out,
  output logic [TIMER_W-1:0] st_out,
  output logic               sound_on_out
);

  localparam int unsigned I_DIV = CLK_HZ / INSTR_HZ;
  localparam int unsigned T_DIV = CLK_HZ / TIMER_HZ;

  if (I_DIV < 2) begin : g_i_div_chk
    $error("chip8_tick_timer: CLK_HZ/INSTR_HZ must be at least 2");
  end
  if (T_DIV < 2) begin : g_t_div_chk
    $error("chip8_tick_timer: CLK_HZ/TIMER_HZ must be at least 2");
  end

  // Single-step strobe request; only honoured while the dividers are halted.
  logic step_c;
`ifdef CHIP8_STEP_EN
  assign step_c = step_in & ~active_in;
`else
  logic unused_step;
  assign unused_step = step_in;
  assign step_c      = 1'b0;
`endif

  chip8_pulse_div #(
    .DIV (I_DIV)
  ) u_instr_div (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .en_in     (active_in),
    .force_in  (step_c),
    .pulse_out (chip8_clk_out)
  );

  // Stepping never advances the timer divider.
  chip8_pulse_div #(
    .DIV (T_DIV)
  ) u_timer_div (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .en_in     (active_in),
    .force_in  (1'b0),
    .pulse_out (timer_tick_out)
  );

  chip8_timer_t dt_q;
  chip8_timer_t st_q;
  chip8_timer_t dt_d;
  chip8_timer_t st_d;

  // DT and ST follow the same rule independently, sampling the registered tick.
  always_comb begin
    dt_d = timer_next(dt_we_in, dt_data_in, timer_tick_out, dt_q);
    st_d = timer_next(st_we_in, st_data_in, timer_tick_out, st_q);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dt_q <= '0;
      st_q <= '0;
    end else begin
      dt_q <= dt_d;
      st_q <= st_d;
    end
  end

  assign dt_out       = dt_q;
  assign st_out       = st_q;
  // Decoded straight from the ST flops, so it only changes on a clock edge or reset.
  assign sound_on_out = (st_q != '0);

endmodule

// File: tb/tb_chip8_tick_timer.sv
// Self-checking bench for chip8_tick_timer (I_DIV=10, T_DIV=20).
module tb_chip8_tick_timer;

  localparam int unsigned I_DIV = 10;
  localparam int unsigned T_DIV = 20;
`ifdef CHIP8_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       active;
  logic       step;
  logic       dt_we;
  logic [7:0] dt_data;
  logic       st_we;
  logic [7:0] st_data;
  logic       chip8_clk;
  logic       timer_tick;
  logic [7:0] dt;
  logic [7:0] st;
  logic       sound_on;

  chip8_tick_timer #(
    .CLK_HZ   (1000),
    .INSTR_HZ (100),
    .TIMER_HZ (50)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .active_in      (active),
    .step_in        (step),
    .dt_we_in       (dt_we),
    .dt_data_in     (dt_data),
    .st_we_in       (st_we),
    .st_data_in     (st_data),
    .chip8_clk_out  (chip8_clk),
    .timer_tick_out (timer_tick),
    .dt_out         (dt),
    .st_out         (st),
    .sound_on_out   (sound_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: active cycles since reset plus the timer values.
  int unsigned act_n;
  int          m_dt;
  int          m_st;
  logic        m_strobe;
  logic        m_tick;

  int unsigned n_assert;
  int unsigned n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act_n    = 0;
    m_dt     = 0;
    m_st     = 0;
    m_strobe = 1'b0;
    m_tick   = 1'b0;
  endtask

  task automatic check_all();
    check("strobe", 32'(chip8_clk), 32'(m_strobe));
    check("tick",   32'(timer_tick), 32'(m_tick));
    check("dt",     32'(dt), 32'(m_dt));
    check("st",     32'(st), 32'(m_st));
    check("sound",  32'(sound_on), 32'(m_st != 0));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cyc();
    @(posedge clk);
    if (dt_we) m_dt = int'(dt_data);
    else if (m_tick && m_dt > 0) m_dt = m_dt - 1;
    if (st_we) m_st = int'(st_data);
    else if (m_tick && m_st > 0) m_st = m_st - 1;
    if (active) begin
      act_n++;
      m_strobe = (act_n % I_DIV) == 0;
      m_tick   = (act_n % T_DIV) == 0;
    end else begin
      m_strobe = STEP_EN && step;
      m_tick   = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_strobe;
    int first_tick;
    int cnt;
    int strobes;
    bit seen;

    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    active   = 1'b0;
    step     = 1'b0;
    dt_we    = 1'b0;
    dt_data  = '0;
    st_we    = 1'b0;
    st_data  = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", 32'(chip8_clk), 32'd0);
    check("rst_tick", 32'(timer_tick), 32'd0);
    check("rst_dt", 32'(dt), 32'd0);
    check("rst_st", 32'(st), 32'd0);
    check("rst_sound", 32'(sound_on), 32'd0);

    // 1: strobe every 10 cycles, tick every 20
    rst_n  = 1'b1;
    active = 1'b1;
    model_reset();
    first_strobe = 0;
    first_tick   = 0;
    strobes      = 0;
    for (int i = 1; i <= 45; i++) begin
      cyc();
      if (chip8_clk) strobes++;
      if (chip8_clk && first_strobe == 0) first_strobe = i;
      if (timer_tick && first_tick == 0) first_tick = i;
    end
    check("first_strobe", 32'(first_strobe), 32'd10);
    check("first_tick", 32'(first_tick), 32'd20);
    check("strobes_45", 32'(strobes), 32'd4);

    // 2: DT load 3, counts down to 0 and stays there
    dt_we   = 1'b1;
    dt_data = 8'd3;
    cyc();
    dt_we   = 1'b0;
    check("dt_load", 32'(dt), 32'd3);
    repeat (90) cyc();
    check("dt_floor", 32'(dt), 32'd0);

    // 3: ST load coincident with a tick is not decremented
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      if (timer_tick) seen = 1'b1;
      else cyc();
    end
    check("tick_found", 32'(seen), 32'd1);
    st_we   = 1'b1;
    st_data = 8'd5;
    cyc();
    st_we   = 1'b0;
    check("st_load_on_tick", 32'(st), 32'd5);
    check("sound_on", 32'(sound_on), 32'd1);
    repeat (110) cyc();
    check("st_floor", 32'(st), 32'd0);
    check("sound_off", 32'(sound_on), 32'd0);

    // Randomised run against the model
    for (int i = 0; i < 800; i++) begin
      active  = ($urandom_range(0, 7) != 0);
      step    = ($urandom_range(0, 3) == 0);
      dt_we   = ($urandom_range(0, 15) == 0);
      dt_data = 8'($urandom_range(0, 12));
      st_we   = ($urandom_range(0, 15) == 0);
      st_data = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 63) == 0) dt_data = 8'($urandom_range(0, 255));
      cyc();
    end
    step  = 1'b0;
    dt_we = 1'b0;
    st_we = 1'b0;

    // 4: pause at count 4 for 7 cycles; next strobe 6 active cycles later
    active = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      cyc();
      if (chip8_clk) seen = 1'b1;
    end
    check("strobe_sync", 32'(seen), 32'd1);
    repeat (4) cyc();
    active  = 1'b0;
    strobes = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (chip8_clk) strobes++;
    end
    check("no_strobe_paused", 32'(strobes), 32'd0);
    active = 1'b1;
    cnt    = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cyc();
      if (chip8_clk) begin
        seen = 1'b1;
        cnt  = i;
      end
    end
    check("resume_latency", 32'(cnt), 32'd6);

    // 5: single step while halted
    active = 1'b0;
    step   = 1'b1;
    cyc();
    step   = 1'b0;
    check("step_strobe", 32'(chip8_clk), 32'(STEP_EN));
    cyc();
    check("step_single", 32'(chip8_clk), 32'd0);
    strobes = 0;
    step    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (chip8_clk) strobes++;
    end
    step = 1'b0;
    check("step_held", 32'(strobes), 32'(STEP_EN ? 3 : 0));
    active = 1'b1;
    repeat (45) cyc();

    // 6: asynchronous reset mid-count with DT=7
    active  = 1'b0;
    dt_we   = 1'b1;
    dt_data = 8'd7;
    st_we   = 1'b1;
    st_data = 8'd9;
    cyc();
    dt_we   = 1'b0;
    st_we   = 1'b0;
    active  = 1'b1;
    check("dt_seven", 32'(dt), 32'd7);
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_strobe", 32'(chip8_clk), 32'd0);
    check("arst_tick", 32'(timer_tick), 32'd0);
    check("arst_dt", 32'(dt), 32'd0);
    check("arst_st", 32'(st), 32'd0);
    check("arst_sound", 32'(sound_on), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cnt  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cyc();
      if (chip8_clk) begin
        seen = 1'b1;
        cnt  = i;
      end
    end
    check("post_rst_strobe", 32'(cnt), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
